// File: rtl/lcd_ctrl_pkg.sv
// rtl/lcd_ctrl_pkg.sv - shared types, init command bytes and command decode for the LCD controller
// Contents:
//   state_t        controller FSM states
//   init byte set  HD44780-style instructions issued by the built-in init sequence
//   is_long_cmd    true for clear-display / return-home, which need the long execution wait
//   init_cmd       init byte for a given init step
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    IDLE,
    SETUP,
    EN_HI,
    HOLD,
    EXEC
  } state_t;

  localparam logic [7:0] INIT_WAKE4  = 8'h20;  // only the high nibble (0x2) is strobed
  localparam logic [7:0] FUNC_SET8   = 8'h38;
  localparam logic [7:0] FUNC_SET4   = 8'h28;
  localparam logic [7:0] DISP_ON     = 8'h0C;
  localparam logic [7:0] CLEAR_DISP  = 8'h01;
  localparam logic [7:0] ENTRY_MODE  = 8'h06;
  localparam logic [2:0] INIT_DONE   = 3'd5;

  // Clear (0x01) and home (0x02/0x03) are the only instructions with data[7:2] == 0.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0);
  endfunction

  // Step 0 exists only on a 4-bit bus; 8-bit builds start the sequence at step 1.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx, input logic bus4);
    case (idx)
      3'd0:    return INIT_WAKE4;
      3'd1:    return bus4 ? FUNC_SET4 : FUNC_SET8;
      3'd2:    return DISP_ON;
      3'd3:    return CLEAR_DISP;
      default: return ENTRY_MODE;
    endcase
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// rtl/lcd_cmd_fifo.sv - synchronous command FIFO with occupancy output
// Ports:
//   clk, rst          clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data   write request and entry; ignored when full
//   pop               read request; ignored when empty
//   head              entry at the read pointer (valid when !empty)
//   level, full, empty occupancy
module lcd_cmd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is not reset; pointer reset alone discards the contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap by overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_ctrl.sv
// rtl/lcd_cmd_ctrl.sv - write-only character LCD command controller with command FIFO and init sequence
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake into the FIFO
//   cmd_rs, cmd_data      0 = instruction, 1 = data; byte to write
//   lcd_data              LCD bus (full byte on 8-bit bus, nibbles high-first on 4-bit bus)
//   lcd_en, lcd_rs        enable strobe and register select
//   lcd_rw                tied low, the busy flag is never read
//   busy                  controller not idle or commands still queued
//   fifo_level            entries held in the FIFO
module lcd_cmd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int BUS_W         = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int T_AS_CYC      = 3,
  parameter int EN_HIGH_CYC   = 12,
  parameter int EXEC_CYC      = 2000,
  parameter int LONG_EXEC_CYC = 80000,
  parameter int POWERUP_CYC   = 750000,
  parameter int INIT_EN       = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rs,
  input  logic [7:0]                  cmd_data,
  output logic [BUS_W-1:0]            lcd_data,
  output logic                        lcd_en,
  output logic                        lcd_rs,
  output logic                        lcd_rw,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  state_t      state;
  logic [31:0] cnt;
  logic [2:0]  init_idx;
  logic        in_init;
  logic        cur_rs;
  logic [7:0]  cur_data;
  logic        nib_lo;   // second (low) nibble of a 4-bit transfer in progress
  logic        single;   // 4-bit wake-up write: high nibble only
  logic        fifo_full;
  logic        fifo_empty;
  logic [8:0]  head;
  logic        pop;
  logic [7:0]  init_byte;
  logic [31:0] exec_lim;

  assign cmd_ready = !fifo_full;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign busy      = (state != IDLE) || (fifo_level != '0);
  assign lcd_rw    = 1'b0;
  assign init_byte = init_cmd(init_idx, BUS_W == 4);
  assign exec_lim  = is_long_cmd(cur_rs, cur_data) ? 32'(LONG_EXEC_CYC) : 32'(EXEC_CYC);

  lcd_cmd_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid && cmd_ready),
    .push_data ({cmd_rs, cmd_data}),
    .pop       (pop),
    .head      (head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  function automatic logic [BUS_W-1:0] beat(input logic [7:0] b, input logic lo);
    if (BUS_W == 8) return BUS_W'(b);
    return lo ? BUS_W'(b[3:0]) : BUS_W'(b[7:4]);
  endfunction

  // Bus outputs are loaded on entry to each phase so they are stable for the
  // whole phase; lcd_en is a flop, so the async reset drops it immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PWRUP;
      cnt      <= '0;
      init_idx <= '0;
      in_init  <= 1'b0;
      cur_rs   <= 1'b0;
      cur_data <= '0;
      nib_lo   <= 1'b0;
      single   <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else begin
      case (state)
        PWRUP: begin
          if (cnt == 32'(POWERUP_CYC - 1)) begin
            cnt <= '0;
            if (INIT_EN != 0) begin
              state    <= INIT;
              in_init  <= 1'b1;
              init_idx <= (BUS_W == 4) ? 3'd0 : 3'd1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        INIT: begin
          if (init_idx == INIT_DONE) begin
            in_init <= 1'b0;
            state   <= IDLE;
          end else begin
            cur_rs   <= 1'b0;
            cur_data <= init_byte;
            single   <= (init_idx == 3'd0);
            nib_lo   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= beat(init_byte, 1'b0);
            init_idx <= init_idx + 3'd1;
            state    <= SETUP;
          end
        end
        IDLE: begin
          if (!fifo_empty) begin
            cur_rs   <= head[8];
            cur_data <= head[7:0];
            single   <= 1'b0;
            nib_lo   <= 1'b0;
            lcd_rs   <= head[8];
            lcd_data <= beat(head[7:0], 1'b0);
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == 32'(T_AS_CYC - 1)) begin
            cnt    <= '0;
            lcd_en <= 1'b1;
            state  <= EN_HI;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        EN_HI: begin
          if (cnt == 32'(EN_HIGH_CYC - 1)) begin
            cnt    <= '0;
            lcd_en <= 1'b0;
            state  <= HOLD;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        HOLD: begin
          if (cnt == 32'(T_AS_CYC - 1)) begin
            cnt <= '0;
            if (BUS_W == 4 && !nib_lo && !single) begin
              nib_lo   <= 1'b1;
              lcd_data <= beat(cur_data, 1'b1);
              state    <= SETUP;
            end else begin
              state <= EXEC;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        EXEC: begin
          if (cnt == exec_lim - 32'd1) begin
            cnt   <= '0;
            state <= in_init ? INIT : IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_ctrl.sv
// tb/tb_lcd_cmd_ctrl.sv - directed self-checking bench for lcd_cmd_ctrl
// dut 0: 8-bit bus, no init; dut 1: 4-bit bus, no init; dut 2: 8-bit bus with init.
// All: T_AS=2, EN_HIGH=4, EXEC=10, LONG_EXEC=40, POWERUP=5, FIFO_DEPTH=4, clock period 10.
module tb_lcd_cmd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst       = 3'b111;
  logic [2:0] cmd_valid = 3'b000;
  logic [2:0] cmd_rs    = 3'b000;
  logic [7:0] cmd_data [3];

  wire  [2:0] cmd_ready, lcd_en, lcd_rs, lcd_rw, busy;
  wire  [7:0] data_a, data_c;
  wire  [3:0] data_b;
  wire  [2:0] lvl [3];
  wire  [7:0] ldat [3];

  assign ldat[0] = data_a;
  assign ldat[1] = {4'h0, data_b};
  assign ldat[2] = data_c;

  lcd_cmd_ctrl #(.BUS_W(8), .FIFO_DEPTH(4), .T_AS_CYC(2), .EN_HIGH_CYC(4), .EXEC_CYC(10),
                 .LONG_EXEC_CYC(40), .POWERUP_CYC(5), .INIT_EN(0)) dut_a (
    .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_rs(cmd_rs[0]), .cmd_data(cmd_data[0]), .lcd_data(data_a), .lcd_en(lcd_en[0]),
    .lcd_rs(lcd_rs[0]), .lcd_rw(lcd_rw[0]), .busy(busy[0]), .fifo_level(lvl[0]));

  lcd_cmd_ctrl #(.BUS_W(4), .FIFO_DEPTH(4), .T_AS_CYC(2), .EN_HIGH_CYC(4), .EXEC_CYC(10),
                 .LONG_EXEC_CYC(40), .POWERUP_CYC(5), .INIT_EN(0)) dut_b (
    .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_rs(cmd_rs[1]), .cmd_data(cmd_data[1]), .lcd_data(data_b), .lcd_en(lcd_en[1]),
    .lcd_rs(lcd_rs[1]), .lcd_rw(lcd_rw[1]), .busy(busy[1]), .fifo_level(lvl[1]));

  lcd_cmd_ctrl #(.BUS_W(8), .FIFO_DEPTH(4), .T_AS_CYC(2), .EN_HIGH_CYC(4), .EXEC_CYC(10),
                 .LONG_EXEC_CYC(40), .POWERUP_CYC(5), .INIT_EN(1)) dut_c (
    .clk(clk), .rst(rst[2]), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
    .cmd_rs(cmd_rs[2]), .cmd_data(cmd_data[2]), .lcd_data(data_c), .lcd_en(lcd_en[2]),
    .lcd_rs(lcd_rs[2]), .lcd_rw(lcd_rw[2]), .busy(busy[2]), .fifo_level(lvl[2]));

  int   checks = 0;
  int   errors = 0;
  int   rw_bad = 0;
  time  push_t;
  time  n0;

  // Strobe monitor: {rs,data} and time at each lcd_en rise, high length at each fall.
  logic [8:0] st_q   [3][$];
  time        st_t   [3][$];
  int         st_len [3][$];
  int         hi_run [3];
  logic [2:0] en_q = 3'b000;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (lcd_rw[i] !== 1'b0) rw_bad++;
      if (lcd_en[i] && !en_q[i]) begin
        st_q[i].push_back({lcd_rs[i], ldat[i]});
        st_t[i].push_back($time);
        hi_run[i] = 0;
      end
      if (lcd_en[i]) hi_run[i]++;
      else if (en_q[i]) st_len[i].push_back(hi_run[i]);
      en_q[i] = lcd_en[i];
    end
  end

  task automatic clear_mon(input int d);
    st_q[d].delete();
    st_t[d].delete();
    st_len[d].delete();
  endtask

  // Called at a negedge; push_t records the negedge before the accepting posedge.
  task automatic push(input int d, input logic rs, input logic [7:0] data);
    int k = 0;
    cmd_valid[d] = 1'b1;
    cmd_rs[d]    = rs;
    cmd_data[d]  = data;
    while (cmd_ready[d] !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    push_t = $time;
    @(negedge clk);
    cmd_valid[d] = 1'b0;
  endtask

  task automatic wait_len(input int d, input int n, input int lim, output bit ok);
    int k = 0;
    while (st_len[d].size() < n && k < lim) begin @(negedge clk); k++; end
    ok = (st_len[d].size() >= n);
  endtask

  task automatic wait_idle(input int d, output bit ok);
    int k = 0;
    while (busy[d] !== 1'b0 && k < 500) begin @(negedge clk); k++; end
    ok = (busy[d] === 1'b0);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++; if (lcd_en[d] !== 1'b0) begin errors++; $display("FAIL reset_en dut%0d got %b exp 0", d, lcd_en[d]); end
      checks++; if (lcd_rs[d] !== 1'b0) begin errors++; $display("FAIL reset_rs dut%0d got %b exp 0", d, lcd_rs[d]); end
      checks++; if (lcd_rw[d] !== 1'b0) begin errors++; $display("FAIL reset_rw dut%0d got %b exp 0", d, lcd_rw[d]); end
      checks++; if (ldat[d] !== 8'h00) begin errors++; $display("FAIL reset_data dut%0d got %h exp 00", d, ldat[d]); end
      checks++; if (lvl[d] !== 3'd0) begin errors++; $display("FAIL reset_level dut%0d got %0d exp 0", d, lvl[d]); end
      checks++; if (busy[d] !== 1'b1) begin errors++; $display("FAIL reset_busy dut%0d got %b exp 1", d, busy[d]); end
      checks++; if (cmd_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d got %b exp 1", d, cmd_ready[d]); end
    end
  endtask

  // Release dut 0 and push on every cycle; pops cannot start until PWRUP ends.
  task automatic test_fifo_full;
    bit ok;
    logic [8:0] exp;
    rst[0] = 1'b0;
    clear_mon(0);
    cmd_valid[0] = 1'b1; cmd_rs[0] = 1'b1; cmd_data[0] = 8'h10;
    for (int k = 1; k < 4; k++) begin @(negedge clk); cmd_data[0] = 8'h10 + 8'(k); end
    @(negedge clk);
    checks++; if (lvl[0] !== 3'd4 || cmd_ready[0] !== 1'b0) begin errors++; $display("FAIL full_at4 level %0d ready %b exp 4 0", lvl[0], cmd_ready[0]); end
    cmd_data[0] = 8'h14;
    @(negedge clk);
    checks++; if (lvl[0] !== 3'd4 || cmd_ready[0] !== 1'b0) begin errors++; $display("FAIL full_hold level %0d ready %b exp 4 0", lvl[0], cmd_ready[0]); end
    @(negedge clk);
    checks++; if (lvl[0] !== 3'd3 || cmd_ready[0] !== 1'b1) begin errors++; $display("FAIL full_firstpop level %0d ready %b exp 3 1", lvl[0], cmd_ready[0]); end
    @(negedge clk);
    checks++; if (lvl[0] !== 3'd4 || cmd_ready[0] !== 1'b0) begin errors++; $display("FAIL full_refill level %0d ready %b exp 4 0", lvl[0], cmd_ready[0]); end
    cmd_valid[0] = 1'b0;
    wait_len(0, 5, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_strobes got %0d exp 5", st_len[0].size()); end
    for (int i = 0; i < 5; i++) begin
      exp = {1'b1, 8'h10 + 8'(i)};
      checks++; if (st_q[0][i] !== exp) begin errors++; $display("FAIL full_order%0d got %h exp %h", i, st_q[0][i], exp); end
    end
  endtask

  task automatic test_single;
    bit ok;
    wait_idle(0, ok);
    clear_mon(0);
    push(0, 1'b1, 8'h41);
    wait_len(0, 1, 100, ok);
    checks++; if (st_q[0][0] !== 9'h141) begin errors++; $display("FAIL single_data got %h exp 141", st_q[0][0]); end
    checks++; if (st_len[0][0] !== 4) begin errors++; $display("FAIL single_en_len got %0d exp 4", st_len[0][0]); end
    checks++; if (st_t[0][0] - push_t !== 40) begin errors++; $display("FAIL single_setup got %0t exp 40", st_t[0][0] - push_t); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    wait_idle(0, ok);
    clear_mon(0);
    push(0, 1'b1, 8'h41);
    push(0, 1'b1, 8'h42);
    wait_len(0, 2, 200, ok);
    checks++; if (st_q[0][1] !== 9'h142) begin errors++; $display("FAIL b2b_data got %h exp 142", st_q[0][1]); end
    checks++; if (st_t[0][1] - st_t[0][0] !== 190) begin errors++; $display("FAIL b2b_gap got %0t exp 190", st_t[0][1] - st_t[0][0]); end
  endtask

  task automatic test_exec_long;
    bit ok;
    wait_idle(0, ok);
    clear_mon(0);
    push(0, 1'b0, 8'h01);
    push(0, 1'b0, 8'h04);
    push(0, 1'b1, 8'h01);
    push(0, 1'b1, 8'h55);
    wait_len(0, 4, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL exec_strobes got %0d exp 4", st_len[0].size()); end
    checks++; if (st_t[0][1] - st_t[0][0] !== 490) begin errors++; $display("FAIL exec_clear got %0t exp 490", st_t[0][1] - st_t[0][0]); end
    checks++; if (st_t[0][2] - st_t[0][1] !== 190) begin errors++; $display("FAIL exec_instr04 got %0t exp 190", st_t[0][2] - st_t[0][1]); end
    checks++; if (st_t[0][3] - st_t[0][2] !== 190) begin errors++; $display("FAIL exec_data01 got %0t exp 190", st_t[0][3] - st_t[0][2]); end
    checks++; if (st_q[0][2] !== 9'h101) begin errors++; $display("FAIL exec_rs got %h exp 101", st_q[0][2]); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int k = 0;
    wait_idle(0, ok);
    push(0, 1'b1, 8'h61);
    push(0, 1'b1, 8'h62);
    push(0, 1'b1, 8'h63);
    while (lcd_en[0] !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    checks++; if (lcd_en[0] !== 1'b1) begin errors++; $display("FAIL mid_en_seen got %b exp 1", lcd_en[0]); end
    #2 rst[0] = 1'b1;
    #1;
    checks++; if (lcd_en[0] !== 1'b0) begin errors++; $display("FAIL mid_en_drop got %b exp 0", lcd_en[0]); end
    checks++; if (lvl[0] !== 3'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", lvl[0]); end
    checks++; if (busy[0] !== 1'b1 || ldat[0] !== 8'h00) begin errors++; $display("FAIL mid_outs busy %b data %h exp 1 00", busy[0], ldat[0]); end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    n0 = $time;
    clear_mon(0);
    push(0, 1'b0, 8'h80);
    wait_len(0, 1, 100, ok);
    checks++; if (st_q[0][0] !== 9'h080) begin errors++; $display("FAIL mid_first got %h exp 080", st_q[0][0]); end
    checks++; if (st_t[0][0] - n0 !== 80) begin errors++; $display("FAIL mid_pwrup got %0t exp 80", st_t[0][0] - n0); end
  endtask

  task automatic test_nibble;
    bit ok;
    rst[1] = 1'b0;
    clear_mon(1);
    push(1, 1'b1, 8'hA5);
    push(1, 1'b1, 8'h3C);
    wait_len(1, 4, 300, ok);
    checks++; if (st_q[1][0] !== 9'h10A) begin errors++; $display("FAIL nib_hi got %h exp 10A", st_q[1][0]); end
    checks++; if (st_q[1][1] !== 9'h105) begin errors++; $display("FAIL nib_lo got %h exp 105", st_q[1][1]); end
    checks++; if (st_q[1][2] !== 9'h103 || st_q[1][3] !== 9'h10C) begin errors++; $display("FAIL nib_second got %h %h exp 103 10C", st_q[1][2], st_q[1][3]); end
    checks++; if (st_len[1][1] !== 4) begin errors++; $display("FAIL nib_len got %0d exp 4", st_len[1][1]); end
    checks++; if (st_t[1][1] - st_t[1][0] !== 80) begin errors++; $display("FAIL nib_gap got %0t exp 80", st_t[1][1] - st_t[1][0]); end
    checks++; if (st_t[1][2] - st_t[1][1] !== 190) begin errors++; $display("FAIL nib_exec got %0t exp 190", st_t[1][2] - st_t[1][1]); end
  endtask

  task automatic test_init;
    bit ok;
    logic [8:0] exp [5];
    time gap_exp [4];
    exp = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h155};
    gap_exp = '{190, 190, 490, 200};
    rst[2] = 1'b0;
    n0 = $time;
    clear_mon(2);
    push(2, 1'b1, 8'h55);
    wait_len(2, 5, 600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL init_strobes got %0d exp 5", st_len[2].size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (st_q[2][i] !== exp[i]) begin errors++; $display("FAIL init_byte%0d got %h exp %h", i, st_q[2][i], exp[i]); end
    end
    checks++; if (st_t[2][0] - n0 !== 80) begin errors++; $display("FAIL init_first got %0t exp 80", st_t[2][0] - n0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (st_t[2][i+1] - st_t[2][i] !== gap_exp[i]) begin errors++; $display("FAIL init_gap%0d got %0t exp %0t", i, st_t[2][i+1] - st_t[2][i], gap_exp[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin cmd_data[i] = 8'h00; hi_run[i] = 0; end
    test_reset;
    test_fifo_full;
    test_single;
    test_back_to_back;
    test_exec_long;
    test_reset_mid;
    test_nibble;
    test_init;
    checks++; if (rw_bad != 0) begin errors++; $display("FAIL rw_low got %0d samples high exp 0", rw_bad); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_ctrl.md
LCD_CMD_CTRL -- requirements
Module: lcd_cmd_ctrl

Interface
REQ-001 SHALL have parameter BUS_W, default 8, LCD data bus width; legal values 8 or 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, command FIFO entries; power of 2, >=2.
REQ-003 SHALL have parameter T_AS_CYC, default 3, address-setup and hold cycles around each enable pulse.
REQ-004 SHALL have parameter EN_HIGH_CYC, default 12, lcd_en high cycles per transfer.
REQ-005 SHALL have parameter EXEC_CYC, default 2000, post-command wait cycles for normal commands and data.
REQ-006 SHALL have parameter LONG_EXEC_CYC, default 80000, post-command wait cycles for clear/home.
REQ-007 SHALL have parameter POWERUP_CYC, default 750000, wait cycles after reset before any LCD access.
REQ-008 SHALL have parameter INIT_EN, default 1, to enable the built-in init sequence.
REQ-009 SHALL have ports: clock in 1, system clock; reset in 1, asynchronous active-high reset.
REQ-010 SHALL have ports: cmd_valid in 1, command offered; cmd_ready out 1, FIFO can accept; cmd_rs in 1, 0=instruction, 1=data; cmd_data in 8, byte.
REQ-011 SHALL have ports: lcd_data out BUS_W, LCD bus; lcd_en out 1, enable strobe; lcd_rs out 1, register select; lcd_rw out 1, read/write.
REQ-012 SHALL have ports: busy out 1, controller not idle or FIFO non-empty; fifo_level out clog2(FIFO_DEPTH)+1, entries held.

Function
REQ-013 SHALL push {cmd_rs,cmd_data} into the FIFO on any cycle with cmd_valid && cmd_ready; cmd_ready = (fifo_level != FIFO_DEPTH).
REQ-014 SHALL, on a simultaneous push and pop, leave fifo_level unchanged and preserve order.
REQ-015 SHALL implement states PWRUP, INIT, IDLE, SETUP, EN_HI, HOLD, EXEC.
REQ-016 SHALL stay in PWRUP for POWERUP_CYC cycles, then go to INIT if INIT_EN=1, else to IDLE.
REQ-017 SHALL issue these instructions in INIT, each with normal transfer and wait, before IDLE:
  - BUS_W=4: single high-nibble write 0x2 first.
  - Function set: 0x38 (BUS_W=8) or 0x28 (BUS_W=4).
  - Then 0x0C, 0x01 (long wait), 0x06.
REQ-018 SHALL accept FIFO pushes during PWRUP/INIT but not pop until IDLE.
REQ-019 SHALL pop the FIFO head in IDLE when non-empty and enter SETUP the next cycle.
REQ-020 SHALL, in SETUP, drive lcd_rs and lcd_data (BUS_W=8: full byte; BUS_W=4: high nibble first) with lcd_en=0 for T_AS_CYC cycles.
REQ-021 SHALL hold lcd_en=1 in EN_HI for EN_HIGH_CYC cycles, then hold lcd_en=0 with data/rs stable in HOLD for T_AS_CYC cycles.
REQ-022 SHALL, for BUS_W=4, repeat SETUP/EN_HI/HOLD for the low nibble before EXEC.
REQ-023 SHALL wait LONG_EXEC_CYC in EXEC when cmd_rs=0 and cmd_data[7:2]=0 (clear/home), else EXEC_CYC, then return to IDLE.
REQ-024 SHALL hold lcd_rw at 0 always (write-only; busy flag not polled).
REQ-025 SHALL assert busy whenever state != IDLE or fifo_level != 0.

Reset
REQ-026 SHALL, while reset is asserted, force:
  - lcd_en=0, lcd_rs=0, lcd_data=0, lcd_rw=0.
  - fifo_level=0, busy=1, state PWRUP, all counters 0.
REQ-027 SHALL, on reset mid-transfer, drop lcd_en within the same cycle asynchronously, discard FIFO contents and re-run PWRUP/INIT after release.

Structure
REQ-028 SHALL place the state enum, init command constants and the clear/home decode function in package lcd_ctrl_pkg.
REQ-029 SHALL implement the FIFO as sub-module lcd_cmd_fifo (parametrised width/depth, level output).

Verification
REQ-030 SHALL verify, with T_AS=2, EN_HIGH=4, EXEC=10, INIT_EN=0, POWERUP=5, BUS_W=8: push (rs=1, 0x41) -> lcd_data=0x41, lcd_rs=1, lcd_en high exactly 4 cycles after 2 setup cycles, next pop not before 10 EXEC cycles.
REQ-031 SHALL verify, as REQ-030 with BUS_W=4: push 0xA5 -> two strobes with lcd_data 0xA then 0x5.
REQ-032 SHALL verify, with LONG_EXEC=40: push (rs=0, 0x01) -> 40-cycle EXEC; push (rs=0, 0x04) -> 10-cycle EXEC.
REQ-033 SHALL verify, with FIFO_DEPTH=4, pushing continuously: cmd_ready low at level 4, rises after first pop; output order matches input order.
REQ-034 SHALL verify INIT_EN=1, BUS_W=8: after POWERUP, strobed bytes are 0x38, 0x0C, 0x01, 0x06, then queued user data.
REQ-035 SHALL verify reset asserted during EN_HI: lcd_en=0 immediately, fifo_level=0, and no strobe before POWERUP_CYC after release.
